aud_dsp: RTL and testbench
==========================

Name: aud_dsp

Overview:
- Playback sample generator. Feeds the I2S DAC serializer that sits directly downstream of it.
- Reads 16-bit signed PCM samples from the external SRAM and applies speed control: fast (decimate), slow zero-order hold, or slow linear interpolation.
- Presents one sample per LRCK frame on o_dac_data, and drives the serializer's enable through o_en.
- Clocked on posedge BCLK. The serializer samples on negedge, so o_dac_data is always stable half a BCLK before the serializer uses it.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 16, sample width (signed two's complement).

Ports:
- i_clk  in  1  BCLK; all logic on posedge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_daclrck  in  1  DAC LRCK from codec; low = left channel being shifted.
- i_start  in  1  1-cycle pulse: play from IDLE, or resume from PAUSE.
- i_pause  in  1  1-cycle pulse: RUN->PAUSE.
- i_stop  in  1  1-cycle pulse: any state->IDLE, rewind.
- i_fast  in  1  fast mode select.
- i_slow_0  in  1  slow, zero-order hold.
- i_slow_1  in  1  slow, linear interpolation.
- i_speed  in  3  factor N = i_speed+1 (1..8).
- i_end_addr  in  ADDR_W  last valid sample address (inclusive).
- i_sram_data  in  DATA_W  SRAM read data for o_sram_addr.
- o_sram_addr  out  ADDR_W  current read address.
- o_dac_data  out  DATA_W  sample to serializer.
- o_en  out  1  serializer enable.
- o_done  out  1  1-cycle pulse on natural end of playback.

Behaviour:
- Reset: state IDLE. All outputs 0. Internal regs (addr, cnt, prev, last flag, lrck_d) are 0.
- Tick: tick = i_daclrck & ~lrck_d (rising LRCK, registered lrck_d). All sample updates happen only on tick. Ticks are at least 32 clocks apart, so i_sram_data is valid at every tick.
- States: IDLE, RUN, PAUSE.
- Command priority: i_stop > i_pause > i_start.
- IDLE:
  - o_en = 0, o_dac_data = 0, addr = 0.
  - i_start -> RUN with cnt=0, prev=0, last=0.
- RUN, first tick after entry:
  - Loads o_dac_data and asserts o_en in the same cycle.
  - o_en stays 1 while in RUN, so the serializer never shifts stale data.
- Mode is evaluated at each tick. Precedence: fast > slow_1 > slow_0 > normal. N=1 in any mode behaves as normal.
- If the mode or N differs from the previous tick, cnt is reset to 0 before use.
- Normal:
  - o_dac_data = i_sram_data; addr += 1.
- Fast:
  - o_dac_data = i_sram_data; addr += N.
- Slow_0:
  - o_dac_data = i_sram_data.
  - cnt increments; at cnt==N-1, cnt=0 and addr += 1.
- Slow_1:
  - o_dac_data = prev + ((cur-prev)*(cnt+1))/N, where cur = i_sram_data.
  - Intermediates are sign-extended to 20 bits. Division truncates toward zero and must match exact integer division for N=1..8.
  - At cnt==N-1, the output equals cur; prev<=cur, cnt=0, addr += 1.
- End of data:
  - When an addr advance would give addr > i_end_addr, set last=1 and hold addr.
  - The next tick: RUN->IDLE, o_done=1 for one cycle, o_en=0, o_dac_data=0, addr=0. The last sample therefore plays one full frame.
  - The address adder is ADDR_W+1 bits; no wrap-around.
- PAUSE:
  - o_en=0, o_dac_data=0.
  - addr, cnt, prev and last are held.
  - i_start -> RUN; output resumes at the next tick from the held position.
- i_stop in RUN/PAUSE: -> IDLE, addr=0, no o_done.
- Simultaneous events:
  - i_stop with end-of-data tick: IDLE, no o_done.
  - i_pause on a tick cycle: pause wins, and the tick is not consumed.
- i_rst_n asserted mid-play: immediate return to reset values. No o_done.

Test Plan:
- Normal: sram[k]=k*10, end=3, start -> ticks output 0,10,20,30. Tick 5: o_done pulse, o_en 0, addr 0.
- Fast N=3 (i_speed=2), end=9 -> outputs sram[0],[3],[6],[9]. Done on the following tick. o_sram_addr never exceeds 9.
- Slow_1 N=4, sram[0]=0, sram[1]=100 -> 0,0,0,0,25,50,75,100. Then slow_1 N=3 with next sample -100 from prev 0 -> -33,-66,-100.
- Slow_0 N=2, sram={5,7} -> 5,5,7,7, then done.
- Pause after 2nd output, wait 5 frames (o_en 0, data 0), start -> 3rd sample continues. Stop in PAUSE -> IDLE, addr 0, no o_done.
- Priority/reset: start+stop same cycle -> stays IDLE. i_rst_n low mid-RUN -> all outputs 0 asynchronously; after release, state IDLE.

Source files
------------

// File: rtl/aud_dsp.sv
// aud_dsp: playback sample generator between the external SRAM and the I2S DAC serializer.
// Emits one sample per rising DACLRCK in normal, fast (decimate), slow-hold or slow-interpolate mode.
module aud_dsp #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_daclrck,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_fast,
    input  logic              i_slow_0,
    input  logic              i_slow_1,
    input  logic [2:0]        i_speed,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic [DATA_W-1:0] i_sram_data,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_dac_data,
    output logic              o_en,
    output logic              o_done
);
    localparam int CALC_W = DATA_W + 4;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;
    typedef enum logic [1:0] {M_NORMAL, M_FAST, M_SLOW0, M_SLOW1} mode_t;

    state_t                   state_q, state_d;
    mode_t                    mode_q, mode_d, mode_cur;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [2:0]               cnt_q, cnt_d, spd_q, spd_d, cnt_use;
    logic [DATA_W-1:0]        prev_q, prev_d, dac_q, dac_d;
    logic                     last_q, last_d, en_q, en_d, done_q, done_d, lrck_q;
    logic                     tick, param_chg, cnt_wrap, advance, overflow;
    logic [3:0]               n_val;
    logic [ADDR_W:0]          step, addr_sum;
    logic signed [CALC_W-1:0] cur_x, prev_x, diff_x, mul_x, div_x, prod_x, quo_x, interp_x;

    assign tick      = i_daclrck & ~lrck_q;
    assign n_val     = {1'b0, i_speed} + 4'd1;
    assign param_chg = (mode_cur != mode_q) || (i_speed != spd_q);
    assign cnt_use   = param_chg ? 3'd0 : cnt_q;
    assign cnt_wrap  = (cnt_use == i_speed);

    // N = 1 collapses every mode to normal playback.
    always_comb begin
        mode_cur = M_NORMAL;
        if (i_speed != 3'd0) begin
            if (i_fast)        mode_cur = M_FAST;
            else if (i_slow_1) mode_cur = M_SLOW1;
            else if (i_slow_0) mode_cur = M_SLOW0;
        end
    end

    always_comb begin
        case (mode_cur)
            M_FAST:           step = (ADDR_W+1)'(n_val);
            M_SLOW0, M_SLOW1: step = cnt_wrap ? (ADDR_W+1)'(1) : '0;
            default:          step = (ADDR_W+1)'(1);
        endcase
    end

    // One extra adder bit so an advance past the top of the address space is still seen as overflow.
    assign addr_sum = {1'b0, addr_q} + step;
    assign advance  = (step != '0);
    assign overflow = advance && (addr_sum > {1'b0, i_end_addr});

    // Signed division truncates toward zero, giving exact integer results for every N.
    assign cur_x    = {{(CALC_W-DATA_W){i_sram_data[DATA_W-1]}}, i_sram_data};
    assign prev_x   = {{(CALC_W-DATA_W){prev_q[DATA_W-1]}}, prev_q};
    assign mul_x    = {{(CALC_W-3){1'b0}}, cnt_use} + {{(CALC_W-1){1'b0}}, 1'b1};
    assign div_x    = {{(CALC_W-4){1'b0}}, n_val};
    assign diff_x   = cur_x - prev_x;
    assign prod_x   = diff_x * mul_x;
    assign quo_x    = prod_x / div_x;
    assign interp_x = prev_x + quo_x;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        spd_d   = spd_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        last_d  = last_q;
        dac_d   = dac_q;
        en_d    = en_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                en_d   = 1'b0;
                dac_d  = '0;
                addr_d = '0;
                if (!i_stop && i_start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    prev_d  = '0;
                    last_d  = 1'b0;
                end
            end

            ST_RUN: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                    last_d  = 1'b0;
                    en_d    = 1'b0;
                    dac_d   = '0;
                end else if (i_pause) begin
                    state_d = ST_PAUSE;
                    en_d    = 1'b0;
                    dac_d   = '0;
                end else if (tick) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        en_d    = 1'b0;
                        dac_d   = '0;
                        addr_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        en_d   = 1'b1;
                        mode_d = mode_cur;
                        spd_d  = i_speed;
                        dac_d  = i_sram_data;
                        cnt_d  = '0;
                        if (mode_cur == M_SLOW0 || mode_cur == M_SLOW1) begin
                            cnt_d = cnt_wrap ? 3'd0 : cnt_use + 3'd1;
                        end
                        if (mode_cur == M_SLOW1) begin
                            dac_d = interp_x[DATA_W-1:0];
                            if (cnt_wrap) prev_d = i_sram_data;
                        end
                        if (overflow)     last_d = 1'b1;
                        else if (advance) addr_d = addr_sum[ADDR_W-1:0];
                    end
                end
            end

            ST_PAUSE: begin
                en_d  = 1'b0;
                dac_d = '0;
                if (i_stop) begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                    last_d  = 1'b0;
                end else if (i_start) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
                dac_d   = '0;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= M_NORMAL;
            spd_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            prev_q  <= '0;
            last_q  <= 1'b0;
            dac_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            lrck_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            spd_q   <= spd_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            last_q  <= last_d;
            dac_q   <= dac_d;
            en_q    <= en_d;
            done_q  <= done_d;
            lrck_q  <= i_daclrck;
        end
    end

    assign o_sram_addr = addr_q;
    assign o_dac_data  = dac_q;
    assign o_en        = en_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_aud_dsp.sv
// tb_aud_dsp: table-driven playback scenarios for aud_dsp plus directed pause/stop/reset sequences.
// A small SRAM array answers o_sram_addr combinationally; LRCK frames are 32 BCLKs.
module tb_aud_dsp;
    logic        clk = 1'b0;
    logic        rst_n, daclrck, start, pause, stop, fast, slow0, slow1;
    logic [2:0]  speed;
    logic [19:0] end_addr, sram_addr;
    logic [15:0] sram_data, dac_data;
    logic        en, done;
    logic [15:0] sram [16];
    int          n_tests = 0;
    int          n_fail = 0;
    int          done_seen = 0;

    typedef struct packed {
        logic             fast;
        logic             slow0;
        logic             slow1;
        logic [2:0]       speed;
        logic [19:0]      end_addr;
        logic             ramp;
        logic [3:0]       n;
        logic [3:0][15:0] mem;
        logic [7:0][15:0] expd;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    assign sram_data = (sram_addr < 20'd16) ? sram[sram_addr[3:0]] : 16'hDEAD;

    aud_dsp #(.ADDR_W(20), .DATA_W(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_daclrck   (daclrck),
        .i_start     (start),
        .i_pause     (pause),
        .i_stop      (stop),
        .i_fast      (fast),
        .i_slow_0    (slow0),
        .i_slow_1    (slow1),
        .i_speed     (speed),
        .i_end_addr  (end_addr),
        .i_sram_data (sram_data),
        .o_sram_addr (sram_addr),
        .o_dac_data  (dac_data),
        .o_en        (en),
        .o_done      (done)
    );

    always @(negedge clk) if (done) done_seen <= done_seen + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " en"},   32'(en),        32'd0);
        chk({tag, " dac"},  32'(dac_data),  32'd0);
        chk({tag, " addr"}, 32'(sram_addr), 32'd0);
    endtask

    task automatic pulse(input logic st, input logic pa, input logic sp);
        start = st; pause = pa; stop = sp;
        @(negedge clk);
        start = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    // Raise LRCK; the following posedge is the tick, outputs are sampled at the next negedge.
    task automatic tick_frame();
        daclrck = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_frame();
        repeat (15) @(negedge clk);
        daclrck = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    task automatic set_mode(input logic f, input logic s0, input logic s1,
                            input logic [2:0] sp, input logic [19:0] ea);
        fast = f; slow0 = s0; slow1 = s1; speed = sp; end_addr = ea;
    endtask

    function automatic logic [3:0][15:0] mm(input int m0, input int m1, input int m2, input int m3);
        logic [3:0][15:0] r;
        r[0] = m0[15:0]; r[1] = m1[15:0]; r[2] = m2[15:0]; r[3] = m3[15:0];
        return r;
    endfunction

    function automatic logic [7:0][15:0] ex(input int e0, input int e1, input int e2, input int e3,
                                            input int e4, input int e5, input int e6, input int e7);
        logic [7:0][15:0] r;
        r[0] = e0[15:0]; r[1] = e1[15:0]; r[2] = e2[15:0]; r[3] = e3[15:0];
        r[4] = e4[15:0]; r[5] = e5[15:0]; r[6] = e6[15:0]; r[7] = e7[15:0];
        return r;
    endfunction

    function automatic vec_t mk(input logic f, input logic s0, input logic s1, input logic [2:0] sp,
                                input logic [19:0] ea, input logic rp, input logic [3:0] n,
                                input logic [3:0][15:0] mem, input logic [7:0][15:0] e);
        vec_t v;
        v.fast = f; v.slow0 = s0; v.slow1 = s1; v.speed = sp; v.end_addr = ea;
        v.ramp = rp; v.n = n; v.mem = mem; v.expd = e;
        return v;
    endfunction

    task automatic run_vec(input int i);
        vec_t        v;
        logic [19:0] max_addr;
        int          seen0;
        v = vecs[i];
        for (int k = 0; k < 16; k++) sram[k[3:0]] = v.ramp ? 16'(k * 10) : 16'h0;
        if (!v.ramp) for (int k = 0; k < 4; k++) sram[k[3:0]] = v.mem[k[1:0]];
        set_mode(v.fast, v.slow0, v.slow1, v.speed, v.end_addr);
        seen0 = done_seen;
        max_addr = '0;
        pulse(1'b1, 1'b0, 1'b0);
        chk($sformatf("v%0d pre-tick en", i), 32'(en), 32'd0);
        for (int k = 0; k < int'(v.n); k++) begin
            tick_frame();
            chk($sformatf("v%0d dac[%0d]", i, k), 32'(dac_data), 32'(v.expd[k[2:0]]));
            chk($sformatf("v%0d en[%0d]", i, k), 32'(en), 32'd1);
            if (sram_addr > max_addr) max_addr = sram_addr;
            end_frame();
        end
        tick_frame();
        chk($sformatf("v%0d done", i), 32'(done), 32'd1);
        chk_idle($sformatf("v%0d end", i));
        chk($sformatf("v%0d addr>end", i), 32'(max_addr > v.end_addr), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d done width", i), 32'(done), 32'd0);
        chk($sformatf("v%0d done count", i), 32'(done_seen - seen0), 32'd1);
        end_frame();
    endtask

    initial begin
        int seen0;
        rst_n = 1'b0; daclrck = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        set_mode(1'b0, 1'b0, 1'b0, 3'd0, 20'd0);
        for (int k = 0; k < 16; k++) sram[k[3:0]] = 16'h0;

        vecs[0] = mk(1'b0, 1'b0, 1'b0, 3'd0, 20'd3, 1'b1, 4'd4, mm(0, 0, 0, 0),       ex(0, 10, 20, 30, 0, 0, 0, 0));
        vecs[1] = mk(1'b1, 1'b0, 1'b0, 3'd2, 20'd9, 1'b1, 4'd4, mm(0, 0, 0, 0),       ex(0, 30, 60, 90, 0, 0, 0, 0));
        vecs[2] = mk(1'b0, 1'b0, 1'b1, 3'd3, 20'd1, 1'b0, 4'd8, mm(0, 100, 0, 0),     ex(0, 0, 0, 0, 25, 50, 75, 100));
        vecs[3] = mk(1'b0, 1'b0, 1'b1, 3'd2, 20'd0, 1'b0, 4'd3, mm(-100, 0, 0, 0),    ex(-33, -66, -100, 0, 0, 0, 0, 0));
        vecs[4] = mk(1'b0, 1'b1, 1'b0, 3'd1, 20'd1, 1'b0, 4'd4, mm(5, 7, 0, 0),       ex(5, 5, 7, 7, 0, 0, 0, 0));
        vecs[5] = mk(1'b0, 1'b0, 1'b1, 3'd0, 20'd2, 1'b1, 4'd3, mm(0, 0, 0, 0),       ex(0, 10, 20, 0, 0, 0, 0, 0));
        vecs[6] = mk(1'b1, 1'b0, 1'b0, 3'd7, 20'd8, 1'b1, 4'd2, mm(0, 0, 0, 0),       ex(0, 80, 0, 0, 0, 0, 0, 0));
        vecs[7] = mk(1'b1, 1'b1, 1'b1, 3'd1, 20'd5, 1'b1, 4'd3, mm(0, 0, 0, 0),       ex(0, 20, 40, 0, 0, 0, 0, 0));
        vecs[8] = mk(1'b0, 1'b0, 1'b1, 3'd7, 20'd0, 1'b0, 4'd8, mm(-7, 0, 0, 0),      ex(0, -1, -2, -3, -4, -5, -6, -7));

        repeat (3) @(negedge clk);
        chk_idle("reset");
        chk("reset done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) run_vec(i);

        // cnt restarts when N changes mid-hold
        sram[0] = 16'd5; sram[1] = 16'd7; sram[2] = 16'd9;
        set_mode(1'b0, 1'b1, 1'b0, 3'd2, 20'd5);
        pulse(1'b1, 1'b0, 1'b0);
        tick_frame(); chk("nchg dac0", 32'(dac_data), 32'd5); end_frame();
        tick_frame(); chk("nchg dac1", 32'(dac_data), 32'd5); end_frame();
        speed = 3'd1;
        tick_frame(); chk("nchg dac2", 32'(dac_data), 32'd5); chk("nchg addr2", 32'(sram_addr), 32'd0); end_frame();
        tick_frame(); chk("nchg dac3", 32'(dac_data), 32'd5); chk("nchg addr3", 32'(sram_addr), 32'd1); end_frame();
        tick_frame(); chk("nchg dac4", 32'(dac_data), 32'd7);
        pulse(1'b0, 1'b0, 1'b1);
        chk_idle("nchg stop");
        end_frame();

        // pause coincident with a tick, resume, then stop from PAUSE
        for (int k = 0; k < 16; k++) sram[k[3:0]] = 16'(k * 10);
        set_mode(1'b0, 1'b0, 1'b0, 3'd0, 20'd5);
        seen0 = done_seen;
        pulse(1'b1, 1'b0, 1'b0);
        tick_frame(); chk("pz dac0", 32'(dac_data), 32'd0); end_frame();
        tick_frame(); chk("pz dac1", 32'(dac_data), 32'd10); end_frame();
        daclrck = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);
        chk("pz en", 32'(en), 32'd0);
        chk("pz dac", 32'(dac_data), 32'd0);
        chk("pz addr held", 32'(sram_addr), 32'd2);
        end_frame();
        for (int f = 0; f < 5; f++) begin
            tick_frame();
            chk($sformatf("pz hold en%0d", f), 32'(en), 32'd0);
            chk($sformatf("pz hold dac%0d", f), 32'(dac_data), 32'd0);
            end_frame();
        end
        pulse(1'b1, 1'b0, 1'b0);
        chk("pz resume pre-tick en", 32'(en), 32'd0);
        tick_frame();
        chk("pz resume dac", 32'(dac_data), 32'd20);
        chk("pz resume en", 32'(en), 32'd1);
        chk("pz resume addr", 32'(sram_addr), 32'd3);
        end_frame();
        pulse(1'b0, 1'b1, 1'b0);
        chk("pz2 addr", 32'(sram_addr), 32'd3);
        pulse(1'b0, 1'b0, 1'b1);
        chk_idle("pz stop");
        tick_frame();
        chk_idle("pz stop tick");
        @(negedge clk);
        chk("pz no done", 32'(done_seen - seen0), 32'd0);
        end_frame();

        // stop on the end-of-data tick suppresses o_done
        set_mode(1'b0, 1'b0, 1'b0, 3'd0, 20'd1);
        seen0 = done_seen;
        pulse(1'b1, 1'b0, 1'b0);
        tick_frame(); chk("eos dac0", 32'(dac_data), 32'd0); end_frame();
        tick_frame(); chk("eos dac1", 32'(dac_data), 32'd10); end_frame();
        daclrck = 1'b1;
        pulse(1'b0, 1'b0, 1'b1);
        chk_idle("eos stop");
        @(negedge clk);
        chk("eos no done", 32'(done_seen - seen0), 32'd0);
        end_frame();

        // start and stop together leave the block idle
        pulse(1'b1, 1'b0, 1'b1);
        tick_frame();
        chk_idle("startstop");
        end_frame();

        // asynchronous reset mid-play
        set_mode(1'b0, 1'b0, 1'b0, 3'd0, 20'd5);
        seen0 = done_seen;
        pulse(1'b1, 1'b0, 1'b0);
        tick_frame(); chk("rst dac0", 32'(dac_data), 32'd0); end_frame();
        tick_frame(); chk("rst dac1", 32'(dac_data), 32'd10);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("rst async");
        chk("rst async done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        end_frame();
        tick_frame();
        chk_idle("rst idle");
        @(negedge clk);
        chk("rst no done", 32'(done_seen - seen0), 32'd0);
        end_frame();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
